// File: rtl/rc4_pkg.sv
// Shared types for the RC4 decrypt sequencer: one-hot phase encoding and the engine memory bundle.
// Pure declarations; no logic, no latency, no flow control.
package rc4_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int KEY_W  = 24;

  typedef enum logic [10:0] {
    IDLE      = 11'b000_0000_0001,
    INIT_GO   = 11'b000_0000_0010,
    INIT_WAIT = 11'b000_0000_0100,
    INIT_ACK  = 11'b000_0000_1000,
    KSA_GO    = 11'b000_0001_0000,
    KSA_WAIT  = 11'b000_0010_0000,
    KSA_ACK   = 11'b000_0100_0000,
    PRGA_GO   = 11'b000_1000_0000,
    PRGA_WAIT = 11'b001_0000_0000,
    PRGA_ACK  = 11'b010_0000_0000,
    DONE      = 11'b100_0000_0000
  } phase_t;

  typedef enum logic [1:0] {
    ENG_NONE,
    ENG_INIT,
    ENG_KSA,
    ENG_PRGA
  } eng_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
  } mem_req_t;

  // Engine that legitimately owns a phase, including its ACK cycle.
  function automatic eng_t phase_owner(phase_t p);
    case (p)
      INIT_GO, INIT_WAIT, INIT_ACK: phase_owner = ENG_INIT;
      KSA_GO, KSA_WAIT, KSA_ACK:    phase_owner = ENG_KSA;
      PRGA_GO, PRGA_WAIT, PRGA_ACK: phase_owner = ENG_PRGA;
      default:                      phase_owner = ENG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// S-memory grant mux and stray-write detector; purely combinational, zero latency.
// No backpressure: engines own the port for whole GO/WAIT phases.
module rc4_mem_mux
  import rc4_pkg::*;
(
  input  phase_t   phase,
  input  mem_req_t init_req,
  input  mem_req_t ksa_req,
  input  mem_req_t prga_req,
  output mem_req_t mem_req,
  output logic     wr_viol
);

  eng_t owner;

  always_comb begin
    owner   = phase_owner(phase);
    mem_req = '0;
    case (phase)
      INIT_GO, INIT_WAIT: mem_req = init_req;
      KSA_GO, KSA_WAIT:   mem_req = ksa_req;
      PRGA_GO, PRGA_WAIT: mem_req = prga_req;
      default:            mem_req = '0;
    endcase
    // The owner writing during its own ACK is dropped silently, not flagged.
    wr_viol = (init_req.wren && owner != ENG_INIT) ||
              (ksa_req.wren  && owner != ENG_KSA)  ||
              (prga_req.wren && owner != ENG_PRGA);
  end

endmodule

// File: rtl/rc4_phase_ctrl.sv
// RC4 decrypt sequencer: init -> KSA -> PRGA with start/finish/rst handshakes and S-memory ownership.
// Moore outputs straight off the one-hot state; engines stall the sequence by holding finish low.
module rc4_phase_ctrl
  import rc4_pkg::*;
#(
  parameter int CYC_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [KEY_W-1:0]  key,
  output logic [KEY_W-1:0]  key_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CYC_W-1:0]  cycles,
  output logic              init_start,
  output logic              ksa_start,
  output logic              prga_start,
  input  logic              init_finish,
  input  logic              ksa_finish,
  input  logic              prga_finish,
  output logic              init_rst,
  output logic              ksa_rst,
  output logic              prga_rst,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  output logic              mem_wren
);

  phase_t   state;
  logic     abort_q;
  logic     start_acc;
  logic     wr_viol;
  mem_req_t init_req, ksa_req, prga_req, mem_req;

  assign init_req = {init_addr, init_wrdata, init_wren};
  assign ksa_req  = {ksa_addr, ksa_wrdata, ksa_wren};
  assign prga_req = {prga_addr, prga_wrdata, prga_wren};

  rc4_mem_mux u_mux (
    .phase    (state),
    .init_req (init_req),
    .ksa_req  (ksa_req),
    .prga_req (prga_req),
    .mem_req  (mem_req),
    .wr_viol  (wr_viol)
  );

  assign mem_addr   = mem_req.addr;
  assign mem_wrdata = mem_req.wrdata;
  assign mem_wren   = mem_req.wren;

  // Abort out of DONE wins over a simultaneous restart.
  assign start_acc = start && (state == IDLE || (state == DONE && !abort));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      abort_q <= 1'b0;
      key_q   <= '0;
      err     <= 1'b0;
      cycles  <= '0;
    end else begin
      abort_q <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        abort_q <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: if (start) state <= INIT_GO;
          INIT_GO:    state <= INIT_WAIT;
          INIT_WAIT:  if (init_finish) state <= INIT_ACK;
          INIT_ACK:   state <= KSA_GO;
          KSA_GO:     state <= KSA_WAIT;
          KSA_WAIT:   if (ksa_finish) state <= KSA_ACK;
          KSA_ACK:    state <= PRGA_GO;
          PRGA_GO:    state <= PRGA_WAIT;
          PRGA_WAIT:  if (prga_finish) state <= PRGA_ACK;
          PRGA_ACK:   state <= DONE;
          default:    state <= IDLE;
        endcase
      end

      if (start_acc) begin
        key_q  <= key;
        err    <= 1'b0;
        cycles <= '0;
      end else begin
        if (wr_viol) err <= 1'b1;
        if (busy && cycles != '1) cycles <= cycles + CYC_W'(1);
      end
    end
  end

  assign busy       = !(state == IDLE || state == DONE);
  assign done       = (state == DONE);
  assign init_start = (state == INIT_GO);
  assign ksa_start  = (state == KSA_GO);
  assign prga_start = (state == PRGA_GO);
  // abort_q is the IDLE cycle right after an abort; every engine is sent home.
  assign init_rst   = (state == INIT_ACK) || abort_q;
  assign ksa_rst    = (state == KSA_ACK)  || abort_q;
  assign prga_rst   = (state == PRGA_ACK) || abort_q;

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: stub engines with random finish delays, event scoreboard and memory-port model.
// A CYC_W=4 twin runs in lockstep on the same inputs to exercise counter saturation.
module tb_rc4_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [23:0] key = '0;
  logic [2:0]  fin = '0;
  logic [7:0]  eaddr [3];
  logic [7:0]  edata [3];
  logic [2:0]  ewren = '0;

  logic [23:0] key_q, key_q4;
  logic        busy, done, err, busy4, done4, err4;
  logic [19:0] cycles;
  logic [3:0]  cycles4;
  logic [2:0]  st, rs, st4, rs4;
  logic [7:0]  mem_addr, mem_wrdata, maddr4, mdata4;
  logic        mem_wren, mwren4;

  always #5 clk = ~clk;

  rc4_phase_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key), .key_q(key_q),
    .busy(busy), .done(done), .err(err), .cycles(cycles),
    .init_start(st[0]), .ksa_start(st[1]), .prga_start(st[2]),
    .init_finish(fin[0]), .ksa_finish(fin[1]), .prga_finish(fin[2]),
    .init_rst(rs[0]), .ksa_rst(rs[1]), .prga_rst(rs[2]),
    .init_addr(eaddr[0]), .init_wrdata(edata[0]), .init_wren(ewren[0]),
    .ksa_addr(eaddr[1]), .ksa_wrdata(edata[1]), .ksa_wren(ewren[1]),
    .prga_addr(eaddr[2]), .prga_wrdata(edata[2]), .prga_wren(ewren[2]),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren)
  );

  rc4_phase_ctrl #(.CYC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key), .key_q(key_q4),
    .busy(busy4), .done(done4), .err(err4), .cycles(cycles4),
    .init_start(st4[0]), .ksa_start(st4[1]), .prga_start(st4[2]),
    .init_finish(fin[0]), .ksa_finish(fin[1]), .prga_finish(fin[2]),
    .init_rst(rs4[0]), .ksa_rst(rs4[1]), .prga_rst(rs4[2]),
    .init_addr(eaddr[0]), .init_wrdata(edata[0]), .init_wren(ewren[0]),
    .ksa_addr(eaddr[1]), .ksa_wrdata(edata[1]), .ksa_wren(ewren[1]),
    .prga_addr(eaddr[2]), .prga_wrdata(edata[2]), .prga_wren(ewren[2]),
    .mem_addr(maddr4), .mem_wrdata(mdata4), .mem_wren(mwren4)
  );

  typedef struct {
    logic [6:0]  ev;   // {done_rise, prga_rst, ksa_rst, init_rst, prga_start, ksa_start, init_start}
    int          cyc;
    bit          e;
    logic [23:0] k;
  } exp_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   nn [3] = '{1, 1, 1};
  int   cnt [3] = '{0, 0, 0};
  bit   run [3] = '{0, 0, 0};
  bit   inj = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stub engines: finish rises after nn[e] WAIT cycles; writes only while running.
  initial begin
    logic [2:0] s_st, s_rs;
    logic       s_ab;
    for (int e = 0; e < 3; e++) begin eaddr[e] = '0; edata[e] = '0; end
    forever begin
      @(negedge clk);
      s_st = st; s_rs = rs; s_ab = abort;
      @(posedge clk); #1;
      for (int e = 0; e < 3; e++) begin
        if (!rst_n || s_rs[e] || s_ab) begin
          run[e] = 1'b0; fin[e] = 1'b0;
        end else if (s_st[e]) begin
          run[e] = 1'b1; cnt[e] = 1; fin[e] = (1 >= nn[e]);
        end else if (run[e] && !fin[e]) begin
          cnt[e]++; fin[e] = (cnt[e] >= nn[e]);
        end
        eaddr[e] = 8'($urandom);
        edata[e] = 8'($urandom);
        ewren[e] = run[e] && ($urandom_range(0, 1) == 1);
      end
      if (inj && run[0] && cnt[0] == 3) begin
        eaddr[0] = 8'h05; edata[0] = 8'h05; ewren[0] = 1'b1;
        eaddr[1] = 8'hAA; ewren[1] = 1'b1;
        inj = 1'b0;
      end
    end
  end

  // Monitor: memory port and err against an ownership model, pulses against the scoreboard.
  initial begin
    int         own, g;
    bit         err_m, done_p;
    logic [6:0] w;
    logic [16:0] expm;
    exp_t       x;
    own = -1; err_m = 1'b0; done_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin own = -1; err_m = 1'b0; done_p = 1'b0; continue; end
      w = {done && !done_p, rs, st};
      done_p = done;
      for (int e = 0; e < 3; e++) if (st[e]) own = e;
      if (st[0]) err_m = 1'b0;
      g = -1;
      if (own >= 0) begin
        if (!rs[own]) g = own;
      end
      expm = (g >= 0) ? {eaddr[g], edata[g], ewren[g]} : 17'd0;
      chk("mem_port", {mem_addr, mem_wrdata, mem_wren}, expm);
      chk("mem_wren_cw4", mwren4, expm[0]);
      chk("err_track", err, err_m);
      for (int e = 0; e < 3; e++) if (ewren[e] && e != own) err_m = 1'b1;
      if (w != 0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got %0h expected none", w);
        end else begin
          x = sb.pop_front();
          chk("event", w, x.ev);
          if (x.ev[6]) begin
            chk("done_cycles", cycles, x.cyc);
            chk("done_cycles_sat4", cycles4, (x.cyc > 15) ? 15 : x.cyc);
            chk("done_err", err, x.e);
            chk("done_key_q", key_q, x.k);
          end
        end
      end
      if (|rs) own = -1;
    end
  end

  task automatic push(logic [6:0] ev, int cyc, bit e, logic [23:0] k);
    exp_t x;
    x.ev = ev; x.cyc = cyc; x.e = e; x.k = k;
    sb.push_back(x);
  endtask

  task automatic push_full(int a, int b, int c, bit e, logic [23:0] k);
    push(7'h01, 0, 0, 0); push(7'h08, 0, 0, 0);
    push(7'h02, 0, 0, 0); push(7'h10, 0, 0, 0);
    push(7'h04, 0, 0, 0); push(7'h20, 0, 0, 0);
    push(7'h40, a + b + c + 6, e, k);
  endtask

  task automatic issue(logic [23:0] k);
    @(posedge clk); #1;
    start = 1'b1; key = k;
    @(posedge clk); #1;
    start = 1'b0; key = 24'($urandom);
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(posedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_stub(string name, int e, int c);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (!(run[e] && cnt[e] >= c) && n < 300);
    checks++;
    if (!(run[e] && cnt[e] >= c)) begin
      errors++;
      $display("FAIL %s_wait: got cnt %0d expected %0d", name, cnt[e], c);
    end
  endtask

  task automatic full_run(string name, logic [23:0] k, int a, int b, int c, bit e);
    nn = '{a, b, c};
    inj = e;
    push_full(a, b, c, e, k);
    issue(k);
    drain(name, a + b + c + 40);
    @(posedge clk); #1;
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] k;
    int a, b, c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cycles", cycles, 0);
    chk("rst_key_q", key_q, 0);
    chk("rst_pulses", {rs, st}, 0);
    chk("rst_mem", {mem_addr, mem_wrdata, mem_wren}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    full_run("full", 24'h000249, 10, 20, 30, 1'b0);
    full_run("grant", 24'h00A5C3, 10, 10, 10, 1'b1);

    // Abort in the middle of KSA.
    k = 24'h13579B;
    nn = '{5, 30, 10};
    push(7'h01, 0, 0, 0); push(7'h08, 0, 0, 0); push(7'h02, 0, 0, 0); push(7'h38, 0, 0, 0);
    issue(k);
    wait_stub("abort", 1, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_mem_wren", mem_wren, 1'b0);
    chk("abort_rsts", rs, 3'b111);
    chk("abort_key_q", key_q, k);
    @(posedge clk); #1;
    chk("abort_rsts_once", rs, 3'b000);
    drain("abort", 5);
    full_run("after_abort", 24'h2468AC, 3, 7, 4, 1'b0);

    // Start while busy must be ignored.
    k = 24'h0F1E2D;
    nn = '{4, 6, 12};
    push_full(4, 6, 12, 1'b0, k);
    issue(k);
    wait_stub("busy_start", 2, 3);
    start = 1'b1; key = 24'hFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_key_q", key_q, k);
    drain("busy_start", 60);
    repeat (4) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      k = 24'($urandom);
      a = $urandom_range(1, 40); b = $urandom_range(1, 40); c = $urandom_range(1, 40);
      if (i % 2 == 1 && a < 4) a = 4;
      full_run("random", k, a, b, c, (i % 2 == 1));
    end

    // Asynchronous reset between clock edges during INIT_WAIT.
    nn = '{20, 5, 5};
    push(7'h01, 0, 0, 0);
    issue(24'h777777);
    wait_stub("areset", 0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_busy", busy, 1'b0);
    chk("areset_done", done, 1'b0);
    chk("areset_err", err, 1'b0);
    chk("areset_cycles", cycles, 0);
    chk("areset_key_q", key_q, 0);
    chk("areset_mem", {mem_addr, mem_wrdata, mem_wren}, 0);
    chk("areset_pulses", {rs, st}, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("areset_hold_busy", busy, 1'b0);
    chk("areset_hold_cycles", cycles, 0);
    chk("areset_hold_key_q", key_q, 0);

    full_run("post_reset", 24'h000249, 2, 2, 2, 1'b0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
